// File: rtl/dsp_result_collector.sv
// dsp_result_collector: tracks valid operand sets through the DSP pipeline, queues P results
// and serializes them least-significant slice first onto a valid/ready stream.
module dsp_result_collector #(
    parameter int P_WIDTH   = 48,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CE,
    input  logic                     IN_VALID,
    input  logic [P_WIDTH-1:0]       P_IN,
    input  logic                     CLR_OVF,
    output logic [OUT_WIDTH-1:0]     OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     OUT_LAST,
    output logic                     FIFO_FULL,
    output logic                     FIFO_EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW
);
    localparam int BEATS = P_WIDTH / OUT_WIDTH;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    logic [LATENCY-1:0] tag, tag_next;
    logic [P_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [BW-1:0]      beat;
    logic               wr, pop, accept, last_beat;

    assign FIFO_FULL  = COUNT == CW'(DEPTH);
    assign FIFO_EMPTY = COUNT == '0;
    assign OUT_VALID  = !FIFO_EMPTY;
    assign last_beat  = beat == BW'(BEATS - 1);
    assign OUT_LAST   = OUT_VALID & last_beat;
    assign pop        = OUT_VALID & OUT_READY & last_beat;
    assign wr         = CE & tag[LATENCY-1];
    // a full FIFO still takes the write when the head retires at the same edge
    assign accept     = wr & (!FIFO_FULL | pop);
    assign OUT_DATA   = OUT_VALID ? mem[rd_ptr][beat*OUT_WIDTH +: OUT_WIDTH] : '0;

    always_comb begin
        tag_next    = tag << 1;
        tag_next[0] = IN_VALID;
    end

    always_ff @(posedge CLK)
        if (accept) mem[wr_ptr] <= P_IN;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            tag      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            beat     <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (CE) tag <= tag_next;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            COUNT <= COUNT + CW'(accept) - CW'(pop);
            if (OUT_VALID & OUT_READY) beat <= last_beat ? '0 : beat + 1'b1;
            OVERFLOW <= (wr & !accept) | (OVERFLOW & !CLR_OVF);
        end
endmodule

// File: tb/tb_dsp_result_collector.sv
// tb_dsp_result_collector: directed scenarios against dsp_result_collector with default parameters.
module tb_dsp_result_collector;
    logic        CLK = 0, RST = 1, CE = 1, IN_VALID = 0, CLR_OVF = 0, OUT_READY = 0;
    logic [47:0] P_IN = '0;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID, OUT_LAST, FIFO_FULL, FIFO_EMPTY, OVERFLOW;
    logic [2:0]  COUNT;
    int          passed = 0, total = 0;

    dsp_result_collector dut (
        .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .P_IN(P_IN), .CLR_OVF(CLR_OVF),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
        .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        @(posedge CLK);
        #1;
        total++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid got=%b exp=0", OUT_VALID); else passed++;
        total++; if (COUNT !== 3'd0) $display("FAIL reset_count got=%0d exp=0", COUNT); else passed++;
        total++; if (FIFO_EMPTY !== 1'b1 || FIFO_FULL !== 1'b0) $display("FAIL reset_flags got=%b%b exp=10", FIFO_EMPTY, FIFO_FULL); else passed++;
        total++; if (OUT_DATA !== 16'h0 || OUT_LAST !== 1'b0 || OVERFLOW !== 1'b0) $display("FAIL reset_outs data=%h last=%b ovf=%b exp=0,0,0", OUT_DATA, OUT_LAST, OVERFLOW); else passed++;
        #3 RST = 0;
        tick;
    endtask

    task automatic test_single;
        OUT_READY = 1;
        IN_VALID = 1;
        tick;
        IN_VALID = 0;
        repeat (3) tick;
        P_IN = 48'h0123_4567_89AB;
        tick;
        P_IN = '0;
        total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h89AB || OUT_LAST !== 1'b0) $display("FAIL single_b0 v=%b d=%h l=%b exp=1,89ab,0", OUT_VALID, OUT_DATA, OUT_LAST); else passed++;
        total++; if (COUNT !== 3'd1) $display("FAIL single_count got=%0d exp=1", COUNT); else passed++;
        tick;
        total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h4567 || OUT_LAST !== 1'b0) $display("FAIL single_b1 v=%b d=%h l=%b exp=1,4567,0", OUT_VALID, OUT_DATA, OUT_LAST); else passed++;
        tick;
        total++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h0123 || OUT_LAST !== 1'b1) $display("FAIL single_b2 v=%b d=%h l=%b exp=1,0123,1", OUT_VALID, OUT_DATA, OUT_LAST); else passed++;
        tick;
        total++; if (OUT_VALID !== 1'b0 || FIFO_EMPTY !== 1'b1 || OUT_DATA !== 16'h0) $display("FAIL single_done v=%b e=%b d=%h exp=0,1,0", OUT_VALID, FIFO_EMPTY, OUT_DATA); else passed++;
    endtask

    task automatic test_ce_stall;
        OUT_READY = 0;
        P_IN = 48'hAAAA_BBBB_CCCC;
        IN_VALID = 1;
        tick;
        IN_VALID = 0;
        tick;
        CE = 0;
        repeat (3) tick;
        CE = 1;
        repeat (2) tick;
        total++; if (COUNT !== 3'd0) $display("FAIL stall_early count=%0d exp=0", COUNT); else passed++;
        tick;
        total++; if (COUNT !== 3'd1 || OUT_DATA !== 16'hCCCC) $display("FAIL stall_capture count=%0d d=%h exp=1,cccc", COUNT, OUT_DATA); else passed++;
        repeat (4) tick;
        total++; if (COUNT !== 3'd1) $display("FAIL stall_no_dup count=%0d exp=1", COUNT); else passed++;
        OUT_READY = 1;
        repeat (3) tick;
        total++; if (FIFO_EMPTY !== 1'b1) $display("FAIL stall_drain empty=%b exp=1", FIFO_EMPTY); else passed++;
        OUT_READY = 0;
        P_IN = '0;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) begin
            IN_VALID = i < 5;
            P_IN = i >= 4 ? 48'(i - 3) : '0;
            tick;
            if (i == 6) begin
                total++; if (FIFO_FULL !== 1'b0 || COUNT !== 3'd3) $display("FAIL ovf_three full=%b count=%0d exp=0,3", FIFO_FULL, COUNT); else passed++;
            end
            if (i == 7) begin
                total++; if (FIFO_FULL !== 1'b1 || OVERFLOW !== 1'b0) $display("FAIL ovf_full full=%b ovf=%b exp=1,0", FIFO_FULL, OVERFLOW); else passed++;
            end
            if (i == 8) begin
                total++; if (OVERFLOW !== 1'b1 || COUNT !== 3'd4) $display("FAIL ovf_drop ovf=%b count=%0d exp=1,4", OVERFLOW, COUNT); else passed++;
            end
        end
        IN_VALID = 0;
        P_IN = '0;
        OUT_READY = 1;
        for (int j = 0; j < 12; j++) begin
            total++; if (OUT_DATA !== (j % 3 == 0 ? 16'(j / 3 + 1) : 16'h0) || OUT_LAST !== (j % 3 == 2)) $display("FAIL ovf_beat%0d d=%h l=%b exp=%h,%b", j, OUT_DATA, OUT_LAST, (j % 3 == 0 ? 16'(j / 3 + 1) : 16'h0), (j % 3 == 2)); else passed++;
            tick;
        end
        total++; if (FIFO_EMPTY !== 1'b1 || OVERFLOW !== 1'b1) $display("FAIL ovf_drained empty=%b ovf=%b exp=1,1", FIFO_EMPTY, OVERFLOW); else passed++;
        OUT_READY = 0;
        CLR_OVF = 1;
        tick;
        CLR_OVF = 0;
        total++; if (OVERFLOW !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); else passed++;
    endtask

    task automatic test_full_pop_write;
        for (int i = 0; i < 9; i++) begin
            IN_VALID = i < 5;
            P_IN = i >= 4 ? 48'h10 + 48'(i - 3) : '0;
            OUT_READY = i >= 6;
            tick;
            if (i == 7) begin
                total++; if (FIFO_FULL !== 1'b1 || OUT_LAST !== 1'b1 || OUT_DATA !== 16'h0) $display("FAIL fpw_pre full=%b last=%b d=%h exp=1,1,0", FIFO_FULL, OUT_LAST, OUT_DATA); else passed++;
            end
        end
        IN_VALID = 0;
        P_IN = '0;
        total++; if (COUNT !== 3'd4 || OVERFLOW !== 1'b0) $display("FAIL fpw_both count=%0d ovf=%b exp=4,0", COUNT, OVERFLOW); else passed++;
        for (int j = 0; j < 12; j++) begin
            total++; if (OUT_DATA !== (j % 3 == 0 ? 16'h12 + 16'(j / 3) : 16'h0)) $display("FAIL fpw_beat%0d d=%h exp=%h", j, OUT_DATA, (j % 3 == 0 ? 16'h12 + 16'(j / 3) : 16'h0)); else passed++;
            tick;
        end
        total++; if (FIFO_EMPTY !== 1'b1) $display("FAIL fpw_drained empty=%b exp=1", FIFO_EMPTY); else passed++;
        OUT_READY = 0;
    endtask

    task automatic test_wrap;
        int idx = 0;
        logic stalled = 0;
        logic [15:0] held = '0;
        logic [15:0] exp;
        for (int c = 0; c < 150 && idx < 30; c++) begin
            IN_VALID = (c % 5 == 0) && (c / 5 < 10);
            P_IN = (c >= 4 && (c - 4) % 5 == 0 && (c - 4) / 5 < 10) ?
                   {16'hC000 + 16'((c - 4) / 5), 16'hB000 + 16'((c - 4) / 5), 16'hA000 + 16'((c - 4) / 5)} : '0;
            OUT_READY = c[0];
            if (stalled) begin
                total++; if (OUT_DATA !== held) $display("FAIL wrap_hold c=%0d d=%h exp=%h", c, OUT_DATA, held); else passed++;
            end
            stalled = 0;
            if (OUT_VALID) begin
                exp = (idx % 3 == 0 ? 16'hA000 : idx % 3 == 1 ? 16'hB000 : 16'hC000) + 16'(idx / 3);
                total++; if (OUT_DATA !== exp) $display("FAIL wrap_beat%0d d=%h exp=%h", idx, OUT_DATA, exp); else passed++;
                if (OUT_READY) idx++;
                else begin
                    stalled = 1;
                    held = OUT_DATA;
                end
            end
            tick;
        end
        IN_VALID = 0;
        P_IN = '0;
        OUT_READY = 0;
        total++; if (idx !== 30) $display("FAIL wrap_count beats=%0d exp=30", idx); else passed++;
        total++; if (FIFO_EMPTY !== 1'b1 || OVERFLOW !== 1'b0) $display("FAIL wrap_end empty=%b ovf=%b exp=1,0", FIFO_EMPTY, OVERFLOW); else passed++;
    endtask

    task automatic test_reset_midstream;
        OUT_READY = 0;
        for (int i = 0; i < 9; i++) begin
            IN_VALID = i < 5;
            P_IN = i >= 4 ? 48'h20 + 48'(i) : '0;
            tick;
        end
        IN_VALID = 0;
        P_IN = 48'hDEAD_BEEF_CAFE;
        OUT_READY = 1;
        repeat (6) tick;
        IN_VALID = 1;
        tick;
        IN_VALID = 0;
        total++; if (COUNT !== 3'd2 || OVERFLOW !== 1'b1 || OUT_DATA !== 16'h0) $display("FAIL rstm_pre count=%0d ovf=%b d=%h exp=2,1,0", COUNT, OVERFLOW, OUT_DATA); else passed++;
        #3 RST = 1;
        #1;
        total++; if (OUT_VALID !== 1'b0 || COUNT !== 3'd0 || OVERFLOW !== 1'b0) $display("FAIL rstm_async v=%b count=%0d ovf=%b exp=0,0,0", OUT_VALID, COUNT, OVERFLOW); else passed++;
        total++; if (FIFO_EMPTY !== 1'b1 || OUT_DATA !== 16'h0 || OUT_LAST !== 1'b0) $display("FAIL rstm_outs e=%b d=%h l=%b exp=1,0,0", FIFO_EMPTY, OUT_DATA, OUT_LAST); else passed++;
        #10 RST = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            total++; if (OUT_VALID !== 1'b0) $display("FAIL rstm_stale%0d v=%b exp=0", k, OUT_VALID); else passed++;
        end
        OUT_READY = 0;
        P_IN = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_ce_stall;
        test_overflow;
        test_full_pop_write;
        test_wrap;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
